ascon_hash_ctrl: RTL and testbench

//  Sequencer that drives ascon_core through Ascon-Hash256 (NIST SP 800-232 Sec. 5) over the core's word-access port.

---
 rtl/ascon_hash_ctrl_pkg.sv | 44 ++++
 rtl/ascon_hash_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_ascon_hash_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_hash_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ascon_hash_ctrl_pkg
//   Shared constants, FSM state type and message padding helper for the
//   Ascon-Hash256 / Ascon-XOF128 sequencer (ascon_hash_ctrl).
//   Contents:
//     IV_HASH256, IV_XOF128  initial values loaded into state word 0
//     ASCON_HASH_WORDS       digest length of Ascon-Hash256 in 64-bit words
//     hash_state_t           sequencer FSM states
//     ascon_pad_fn()         pads a partial little-endian message beat
// ----------------------------------------------------------------------------
package ascon_hash_ctrl_pkg;

   localparam logic [63:0] IV_HASH256       = 64'h0000_0801_00CC_0002;
   localparam logic [63:0] IV_XOF128        = 64'h0000_0800_00CC_0003;
   localparam int          ASCON_HASH_WORDS = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_PSTART  = 3'd2,
      ST_PWAIT   = 3'd3,
      ST_ABSORB  = 3'd4,
      ST_PAD     = 3'd5,
      ST_SQUEEZE = 3'd6
   } hash_state_t;

   // Keeps the low nbytes bytes of data and places the 0x01 padding byte
   // directly above them. A full beat (8 bytes, or more, which is clamped)
   // passes through untouched; its padding goes in a separate block.
   function automatic logic [63:0] ascon_pad_fn(input logic [63:0] data,
                                                input logic [3:0]  nbytes);
      logic [3:0]  nb;
      logic [6:0]  sh;
      logic [63:0] mask;
      nb = (nbytes > 4'd8) ? 4'd8 : nbytes;
      sh = {nb, 3'b000};
      if (nb == 4'd8) begin
         return data;
      end
      mask = (64'h1 << sh) - 64'h1;
      return (data & mask) ^ (64'h1 << sh);
   endfunction

endpackage

// File: rtl/ascon_hash_ctrl.sv
// ----------------------------------------------------------------------------
// ascon_hash_ctrl
//   Sequencer that runs Ascon-Hash256 on an ascon_core through its word
//   access port: loads the IV, absorbs a 64-bit little-endian message stream
//   with padding, and squeezes the digest out as a 64-bit word stream.
//
//   Optional feature macro: ASCON_HASH_XOF_EN
//     When defined, xof_i and out_words_i are added (sampled with start_i);
//     xof_i=1 selects IV_XOF128 and out_words_i output words (0 -> 1).
//     When undefined, Hash256 only with a fixed 4-word digest.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     start_i / busy_o    start pulse (IDLE only) / operation in progress
//     msg_*               message beat stream (valid/ready, data, bytes, last)
//     dig_*               digest word stream (valid/ready, data, last)
//     core_start_o        permutation start pulse to the core
//     core_rnd12_o        round configuration, always 12 rounds
//     core_sel_o          state word select
//     core_wdata_o        write data
//     core_we_o           write enable
//     core_xor_o          xor-into-word instead of overwrite
//     core_rdata_i        selected state word from the core
//     core_ready_i        core idle / permutation finished
// ----------------------------------------------------------------------------
module ascon_hash_ctrl
   import ascon_hash_ctrl_pkg::*;
#(
   parameter int XOF_LEN_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
`ifdef ASCON_HASH_XOF_EN
   input  logic                 xof_i,
   input  logic [XOF_LEN_W-1:0] out_words_i,
`endif
   output logic                 busy_o,
   input  logic                 msg_valid_i,
   output logic                 msg_ready_o,
   input  logic [63:0]          msg_data_i,
   input  logic [3:0]           msg_bytes_i,
   input  logic                 msg_last_i,
   output logic                 dig_valid_o,
   input  logic                 dig_ready_i,
   output logic [63:0]          dig_data_o,
   output logic                 dig_last_o,
   output logic                 core_start_o,
   output logic                 core_rnd12_o,
   output logic [2:0]           core_sel_o,
   output logic [63:0]          core_wdata_o,
   output logic                 core_we_o,
   output logic                 core_xor_o,
   input  logic [63:0]          core_rdata_i,
   input  logic                 core_ready_i
);

   // The word counter indexes LOAD words (0..4) and squeeze words (0..N-1).
   localparam int CNT_W = (XOF_LEN_W > 3) ? XOF_LEN_W : 3;

   hash_state_t      state_q, state_d;
   hash_state_t      ret_q, ret_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             guard_q, guard_d;
   logic [CNT_W-1:0] last_idx;
   logic [63:0]      iv_w;
   logic [3:0]       msg_nb;

`ifdef ASCON_HASH_XOF_EN
   logic             xof_q, xof_d;
   logic [CNT_W-1:0] last_q, last_d;

   assign last_idx = last_q;
   assign iv_w     = xof_q ? IV_XOF128 : IV_HASH256;
`else
   assign last_idx = CNT_W'(ASCON_HASH_WORDS - 1);
   assign iv_w     = IV_HASH256;
`endif

   assign msg_nb       = (msg_bytes_i > 4'd8) ? 4'd8 : msg_bytes_i;
   assign core_rnd12_o = 1'b1;
   assign busy_o       = (state_q != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ret_q   <= ST_IDLE;
         cnt_q   <= '0;
         guard_q <= 1'b0;
`ifdef ASCON_HASH_XOF_EN
         xof_q   <= 1'b0;
         last_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
         guard_q <= guard_d;
`ifdef ASCON_HASH_XOF_EN
         xof_q   <= xof_d;
         last_q  <= last_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      ret_d        = ret_q;
      cnt_d        = cnt_q;
      guard_d      = guard_q;
`ifdef ASCON_HASH_XOF_EN
      xof_d        = xof_q;
      last_d       = last_q;
`endif
      msg_ready_o  = 1'b0;
      dig_valid_o  = 1'b0;
      dig_data_o   = '0;
      dig_last_o   = 1'b0;
      core_start_o = 1'b0;
      core_sel_o   = '0;
      core_wdata_o = '0;
      core_we_o    = 1'b0;
      core_xor_o   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               cnt_d   = '0;
               state_d = ST_LOAD;
`ifdef ASCON_HASH_XOF_EN
               xof_d   = xof_i;
               if (!xof_i) begin
                  last_d = CNT_W'(ASCON_HASH_WORDS - 1);
               end else if (out_words_i == '0) begin
                  last_d = '0;
               end else begin
                  last_d = CNT_W'(out_words_i) - CNT_W'(1);
               end
`endif
            end
         end

         ST_LOAD: begin
            core_we_o    = 1'b1;
            core_sel_o   = cnt_q[2:0];
            core_wdata_o = (cnt_q == '0) ? iv_w : 64'h0;
            if (cnt_q == CNT_W'(4)) begin
               cnt_d   = '0;
               ret_d   = ST_ABSORB;
               state_d = ST_PSTART;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_PSTART: begin
            core_start_o = 1'b1;
            guard_d      = 1'b1;
            state_d      = ST_PWAIT;
         end

         // The core may still report ready in the cycle after the start
         // pulse, so the first PWAIT cycle never looks at core_ready_i.
         ST_PWAIT: begin
            if (guard_q) begin
               guard_d = 1'b0;
            end else if (core_ready_i) begin
               state_d = ret_q;
            end
         end

         ST_ABSORB: begin
            msg_ready_o = 1'b1;
            if (msg_valid_i) begin
               core_we_o    = 1'b1;
               core_xor_o   = 1'b1;
               core_wdata_o = ascon_pad_fn(msg_data_i, msg_bytes_i);
               state_d      = ST_PSTART;
               if (!msg_last_i) begin
                  ret_d = ST_ABSORB;
               end else if (msg_nb == 4'd8) begin
                  ret_d = ST_PAD;
               end else begin
                  ret_d = ST_SQUEEZE;
               end
            end
         end

         // A message ending on a full beat needs a block holding only 0x01.
         ST_PAD: begin
            core_we_o    = 1'b1;
            core_xor_o   = 1'b1;
            core_wdata_o = 64'h1;
            ret_d        = ST_SQUEEZE;
            state_d      = ST_PSTART;
         end

         ST_SQUEEZE: begin
            dig_valid_o = 1'b1;
            dig_data_o  = core_rdata_i;
            dig_last_o  = (cnt_q == last_idx);
            if (dig_ready_i) begin
               if (cnt_q == last_idx) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  ret_d   = ST_SQUEEZE;
                  state_d = ST_PSTART;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ascon_hash_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ascon_hash_ctrl
//   Bench for ascon_hash_ctrl. Contains a behavioural ascon_core (p12 with a
//   14-cycle start-to-ready latency) and a scoreboard: expected digest words
//   are queued when a hash is launched and popped by a monitor on every
//   digest handshake. With ASCON_HASH_XOF_EN defined, the XOF ports are
//   connected and the XOF case is exercised.
// ----------------------------------------------------------------------------
module tb_ascon_hash_ctrl;

   typedef logic [4:0][63:0] st_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic        msg_valid;
   logic        msg_ready;
   logic [63:0] msg_data;
   logic [3:0]  msg_bytes;
   logic        msg_last;
   logic        dig_valid;
   logic        dig_ready;
   logic [63:0] dig_data;
   logic        dig_last;
   logic        core_start;
   logic        core_rnd12;
   logic [2:0]  core_sel;
   logic [63:0] core_wdata;
   logic        core_we;
   logic        core_xor;
   logic [63:0] core_rdata;
   logic        core_ready;
`ifdef ASCON_HASH_XOF_EN
   logic        xof;
   logic [7:0]  out_words;
`endif

   int checks   = 0;
   int failures = 0;

   ascon_hash_ctrl #(.XOF_LEN_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
`ifdef ASCON_HASH_XOF_EN
      .xof_i        (xof),
      .out_words_i  (out_words),
`endif
      .busy_o       (busy),
      .msg_valid_i  (msg_valid),
      .msg_ready_o  (msg_ready),
      .msg_data_i   (msg_data),
      .msg_bytes_i  (msg_bytes),
      .msg_last_i   (msg_last),
      .dig_valid_o  (dig_valid),
      .dig_ready_i  (dig_ready),
      .dig_data_o   (dig_data),
      .dig_last_o   (dig_last),
      .core_start_o (core_start),
      .core_rnd12_o (core_rnd12),
      .core_sel_o   (core_sel),
      .core_wdata_o (core_wdata),
      .core_we_o    (core_we),
      .core_xor_o   (core_xor),
      .core_rdata_i (core_rdata),
      .core_ready_i (core_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- Ascon permutation reference ----------------
   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic st_t p12(input st_t s);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
      for (int r = 0; r < 12; r++) begin
         x2 = x2 ^ 64'(240 - 15 * r);
         x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
         t0 = x0 ^ (~x1 & x2);
         t1 = x1 ^ (~x2 & x3);
         t2 = x2 ^ (~x3 & x4);
         t3 = x3 ^ (~x4 & x0);
         t4 = x4 ^ (~x0 & x1);
         t1 = t1 ^ t0; t0 = t0 ^ t4; t3 = t3 ^ t2; t2 = ~t2;
         x0 = t0 ^ ror(t0, 19) ^ ror(t0, 28);
         x1 = t1 ^ ror(t1, 61) ^ ror(t1, 39);
         x2 = t2 ^ ror(t2, 1)  ^ ror(t2, 6);
         x3 = t3 ^ ror(t3, 10) ^ ror(t3, 17);
         x4 = t4 ^ ror(t4, 7)  ^ ror(t4, 41);
      end
      return {x4, x3, x2, x1, x0};
   endfunction

   // ---------------- behavioural ascon_core ----------------
   st_t cs;
   st_t pend;
   int  busy_cnt = 0;
   int  n_starts = 0;
   int  n_xor    = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cnt <= 0;
      end else begin
         if (core_start) begin
            pend     <= p12(cs);
            busy_cnt <= 14;
         end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) cs <= pend;
         end
         if (core_we) begin
            if (core_xor) cs[core_sel] <= cs[core_sel] ^ core_wdata;
            else          cs[core_sel] <= core_wdata;
         end
      end
   end

   // Ready stays high for one cycle after the start pulse, like a core that
   // has not yet left its idle state.
   assign core_ready = (busy_cnt == 0) || (busy_cnt == 14);
   assign core_rdata = cs[core_sel];

   always @(posedge clk) begin
      if (core_start)          n_starts <= n_starts + 1;
      if (core_we && core_xor) n_xor    <= n_xor + 1;
   end

   // ---------------- scoreboard ----------------
   logic [64:0] exp_q[$];
   logic [7:0]  mbuf [0:39];
   bit          bp_mode = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Standard sponge: pad message bytes with 0x01, absorb 8-byte blocks
   // into word 0 with p12 after each, squeeze word 0 with p12 between words.
   function automatic void push_ref(input int len, input logic [63:0] iv, input int nw);
      st_t         s;
      logic [7:0]  p [0:39];
      logic [63:0] blk;
      int          nbl;
      for (int i = 0; i < 40; i++) begin
         if (i < len)       p[i] = mbuf[i];
         else if (i == len) p[i] = 8'h01;
         else               p[i] = 8'h00;
      end
      s    = '0;
      s[0] = iv;
      s    = p12(s);
      nbl  = len / 8 + 1;
      for (int b = 0; b < nbl; b++) begin
         blk = '0;
         for (int k = 0; k < 8; k++) blk[8*k +: 8] = p[8*b + k];
         s[0] = s[0] ^ blk;
         s    = p12(s);
      end
      for (int w = 0; w < nw; w++) begin
         exp_q.push_back({(w == nw - 1), s[0]});
         if (w < nw - 1) s = p12(s);
      end
   endfunction

   // Monitor: compares each handshaken digest word, and checks that a word
   // held under backpressure keeps its data.
   initial begin : monitor
      logic [64:0] e;
      logic        hold_v;
      logic [63:0] hold_d;
      hold_v = 1'b0;
      hold_d = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v) check("dig_hold_stable", {dig_valid, dig_data[62:0]},
                              {1'b1, hold_d[62:0]});
            if (hold_v) check("dig_hold_msb", {63'h0, dig_data[63]}, {63'h0, hold_d[63]});
            if (dig_valid && dig_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL dig_unexpected: got %h last=%b expected no word", dig_data, dig_last);
               end else begin
                  e = exp_q.pop_front();
                  check("dig_data", dig_data, e[63:0]);
                  check("dig_last", {63'h0, dig_last}, {63'h0, e[64]});
               end
            end
            hold_v = dig_valid && !dig_ready;
            hold_d = dig_data;
         end
      end
   end

   // Digest consumer: always ready, or in backpressure mode 10 stall cycles per word.
   initial begin : consumer
      int hold;
      hold = 0;
      dig_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (!bp_mode) begin
            dig_ready = 1'b1;
            hold = 0;
         end else if (dig_valid) begin
            if (hold < 10) begin
               dig_ready = 1'b0;
               hold++;
            end else begin
               dig_ready = 1'b1;
               hold = 0;
            end
         end else begin
            dig_ready = 1'b0;
            hold = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [3:0] nb, input logic last);
      int w;
      msg_valid = 1'b1;
      msg_data  = d;
      msg_bytes = nb;
      msg_last  = last;
      w = 0;
      @(negedge clk);
      while (!msg_ready && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (!msg_ready) begin
         checks++;
         failures++;
         $display("FAIL msg_accept_timeout: ready=%b after %0d cycles, required 1", msg_ready, w);
      end
      @(posedge clk);
      #1;
      msg_valid = 1'b0;
      msg_last  = 1'b0;
   endtask

   // Bytes beyond the valid count are filled with 0xA5 so masking is exercised.
   task automatic send_msg(input int len, input bit poke);
      int          nb;
      int          rem;
      logic [63:0] d;
      nb = (len == 0) ? 1 : (len + 7) / 8;
      for (int b = 0; b < nb; b++) begin
         rem = len - 8 * b;
         if (rem > 8) rem = 8;
         for (int k = 0; k < 8; k++) d[8*k +: 8] = (k < rem) ? mbuf[8*b + k] : 8'hA5;
         send_beat(d, 4'(rem), (b == nb - 1));
         if (poke) pulse_start();
      end
   endtask

   task automatic wait_done(input string name);
      int w;
      w = 0;
      while ((busy || exp_q.size() != 0) && w < 3000) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w >= 3000) begin
         failures++;
         $display("FAIL %s_timeout: busy=%b pending=%0d after %0d cycles, required idle", name, busy, exp_q.size(), w);
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Expected words must already be queued before this is called.
   task automatic run_hash(input string name, input int len, input bit poke,
                           input int exp_starts, input int exp_xor);
      int s0;
      int x0;
      s0 = n_starts;
      x0 = n_xor;
      pulse_start();
      if (poke) pulse_start();
      send_msg(len, poke);
      wait_done(name);
      check({name, "_perm_starts"}, 64'(n_starts - s0), 64'(exp_starts));
      check({name, "_absorb_xors"}, 64'(n_xor - x0), 64'(exp_xor));
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ctrl_outs"},
            {54'h0, busy, msg_ready, dig_valid, dig_last, core_start, core_we, core_xor, core_sel},
            64'h0);
      check({name, "_rnd12"}, {63'h0, core_rnd12}, 64'h1);
   endtask

   task automatic push_kat_empty();
      exp_q.push_back({1'b0, 64'h986b2f0f85e53b0b});
      exp_q.push_back({1'b0, 64'h649ba8de8f9ff2ca});
      exp_q.push_back({1'b0, 64'h838f9b24aa70faa1});
      exp_q.push_back({1'b1, 64'hb2924d30aa3bd59b});
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin : main
      rst_n     = 1'b0;
      start     = 1'b0;
      msg_valid = 1'b0;
      msg_data  = '0;
      msg_bytes = '0;
      msg_last  = 1'b0;
`ifdef ASCON_HASH_XOF_EN
      xof       = 1'b0;
      out_words = 8'd0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Empty message against the NIST Hash256 KAT.
      push_kat_empty();
      run_hash("empty", 0, 1'b0, 5, 1);

      // Full 8-byte message: needs the extra padding block.
      for (int i = 0; i < 8; i++) mbuf[i] = 8'(i);
      push_ref(8, 64'h0000_0801_00CC_0002, 4);
      run_hash("full8", 8, 1'b0, 6, 2);

      // Same message with an out-of-range byte count, which acts as 8.
      begin : over8
         int s0;
         s0 = n_starts;
         push_ref(8, 64'h0000_0801_00CC_0002, 4);
         pulse_start();
         send_beat(64'h0706050403020100, 4'd12, 1'b1);
         wait_done("bytes12");
         check("bytes12_perm_starts", 64'(n_starts - s0), 64'd6);
      end

      // Backpressure on every digest word; digest identical to the empty KAT.
      bp_mode = 1'b1;
      push_kat_empty();
      run_hash("backpressure", 0, 1'b0, 5, 1);
      bp_mode = 1'b0;
      @(posedge clk);
      #1;

      // Reset while waiting on an absorb permutation.
      for (int i = 0; i < 16; i++) mbuf[i] = 8'(8'h30 + i);
      pulse_start();
      send_beat({mbuf[7], mbuf[6], mbuf[5], mbuf[4], mbuf[3], mbuf[2], mbuf[1], mbuf[0]},
                4'd8, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) mbuf[i] = 8'(8'hC0 + i);
      push_ref(3, 64'h0000_0801_00CC_0002, 4);
      run_hash("after_reset", 3, 1'b0, 5, 1);

      // Start pulses while busy are ignored; two-beat message.
      for (int i = 0; i < 12; i++) mbuf[i] = 8'(i * 7 + 1);
      push_ref(12, 64'h0000_0801_00CC_0002, 4);
      run_hash("start_busy", 12, 1'b1, 6, 2);

`ifdef ASCON_HASH_XOF_EN
      // XOF128, 5 output words, empty message.
      xof       = 1'b1;
      out_words = 8'd5;
      push_ref(0, 64'h0000_0800_00CC_0003, 5);
      run_hash("xof5", 0, 1'b0, 6, 1);

      // out_words=0 yields a single word.
      out_words = 8'd0;
      push_ref(0, 64'h0000_0800_00CC_0003, 1);
      run_hash("xof0", 0, 1'b0, 2, 1);
      xof = 1'b0;
`endif

      check_reset_outputs("final_idle");
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
